data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory port (wr, rd, addr, wr_data, rd_data). It accepts one load or store at a time and holds it for a programmable number of wait states. It then performs the RISC-V byte, half or word access with sign or zero extension, and returns the result with a completion pulse. A busy flag lets the pipeline stall while an access is in flight.

Parameters:
DATA_W, 32, data word width (fixed at 32 for RV32 lane logic)
ADDR_W, 9, byte-address width; the array holds 2^ADDR_W/4 words (128)
LATENCY, 2, wait-state cycles between accept and response (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge)
wr  input  1  store request
rd  input  1  load request
addr  input  ADDR_W  byte address
wr_data  input  DATA_W  store data, right-aligned
funct3  input  3  access size and extension (RISC-V load/store encoding)
rd_data  output  DATA_W  registered, extended load result
busy  output  1  high while a request is being serviced
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, only asserted together with done

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE; the wait counter clears.
  - rd_data=0, busy=0, done=0, err=0.
  - The memory array is not cleared.
  - Reset overrides any in-flight request. A store not yet committed is discarded.
- FSM states are IDLE, WAIT and RESP. busy = (state != IDLE). done = (state == RESP).
- Accept:
  - Happens in IDLE at an edge where (wr|rd)==1.
  - addr, wr_data, funct3 and the op type are latched.
  - Next state is WAIT with counter = LATENCY-1. If LATENCY==0, next state is RESP.
  - While busy, wr and rd are ignored; no queueing.
- WAIT: the counter decrements each edge. At an edge where counter==0, the access executes and the state moves to RESP.
- RESP: lasts exactly one cycle with done=1, then returns to IDLE. A new request can be accepted at the edge that leaves RESP? No: acceptance is only in IDLE, so the earliest next accept is the edge after RESP.
- Latency: accept at edge E0, RESP entered at edge E0+LATENCY, done high for the cycle following that edge. busy is high for LATENCY+1 cycles.
- Access execution happens at the edge entering RESP. The store commits and rd_data updates on that same edge.
- Word index is addr[ADDR_W-1:2]; lane is addr[1:0]. Every address is in range; no wrap logic is needed.
- Loads:
  - 000 LB: sign-extend byte at the lane.
  - 001 LH: sign-extend half at addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Stores:
  - 000 SB: wr_data[7:0] into the lane.
  - 001 SH: wr_data[15:0] into half addr[1].
  - 010 SW: full word.
  - Lanes that are not written keep their contents.
- Error (err=1 with done):
  - Cases: a half access with addr[0]=1; a word access with addr[1:0]!=0; an illegal funct3 for the op; wr and rd both high at accept.
  - On error there is no memory write and rd_data holds its previous value.
  - Timing is identical to a normal access.
- rd_data holds its value until the next successful load. Stores do not alter it.

Test Plan:
- Reset: drive reset=0 for 2 edges, including mid-WAIT -> rd_data=0, busy=0, done=0, err=0 on the following cycle.
- LATENCY=2, SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> busy high 3 cycles per access, done in the 3rd cycle, rd_data=0xDEADBEEF, err=0.
- SB 0x80 at 0x013, then read back:
  - LW 0x010 -> 0x80ADBEEF
  - LB 0x013 -> 0xFFFFFF80
  - LBU 0x013 -> 0x00000080
  - LH 0x012 -> 0xFFFF80AD
  - LHU 0x012 -> 0x000080AD
- Errors:
  - LW at 0x011 -> done=1, err=1, rd_data unchanged.
  - SH at 0x013 -> err=1, word at 0x010 unchanged.
  - wr=rd=1 -> err=1, no write.
- Busy-drop and reset abort:
  - Pulse rd again while busy -> ignored; exactly one done.
  - SW 0x12345678 to 0x020 followed by reset=0 in WAIT, then LW 0x020 -> old contents returned.
- LATENCY=0 build: LW accept -> done in the very next cycle, busy high 1 cycle.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-memory port bundle shared by the core (master) and the memory responder (slave).
interface data_mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output wr, rd, addr, wr_data, funct3,
    input  rd_data, busy, done, err
  );

  modport slave (
    input  wr, rd, addr, wr_data, funct3,
    output rd_data, busy, done, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: programmable wait states, then an
// RV32 byte/half/word load or store with sign/zero extension and error reporting.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int         WORDS    = 2 ** (ADDR_W - 2);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_wr, lat_rd;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [2:0]        lat_f3;
  logic [DATA_W-1:0] rd_data_q;
  logic              busy_q, done_q, err_q;

  logic [DATA_W-1:0] mem [WORDS];

  logic              op_wr, op_rd;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic [2:0]        op_f3;
  logic              req, exec;
  logic [ADDR_W-3:0] idx;
  logic [1:0]        lane;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] cur_word, load_val, store_val, mask, lane_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              bad_f3, misaligned, acc_err;

  // With zero wait states the access executes on the accept edge, so the
  // operands come straight from the bus while idle and from the latch otherwise.
  always_comb begin
    op_wr   = lat_wr;
    op_rd   = lat_rd;
    op_addr = lat_addr;
    op_data = lat_data;
    op_f3   = lat_f3;
    if (state == IDLE) begin
      op_wr   = bus.wr;
      op_rd   = bus.rd;
      op_addr = bus.addr;
      op_data = bus.wr_data;
      op_f3   = bus.funct3;
    end
    req  = bus.wr | bus.rd;
    exec = ((state == IDLE) && req && ZERO_LAT) || ((state == WAIT) && (cnt == 4'd0));

    idx      = op_addr[ADDR_W-1:2];
    lane     = op_addr[1:0];
    shamt    = {lane, 3'b000};
    cur_word = mem[idx];
    byte_v   = 8'(cur_word >> shamt);
    half_v   = op_addr[1] ? cur_word[31:16] : cur_word[15:0];

    load_val = '0;
    case (op_f3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = cur_word;
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = '0;
    endcase

    if (op_wr)
      bad_f3 = !(op_f3 inside {3'b000, 3'b001, 3'b010});
    else
      bad_f3 = !(op_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_f3[1:0] == 2'b10) && (lane != 2'b00));
    acc_err    = (op_wr & op_rd) | bad_f3 | misaligned;

    case (op_f3[1:0])
      2'b00: begin
        mask      = 32'h0000_00FF << shamt;
        lane_data = {4{op_data[7:0]}};
      end
      2'b01: begin
        mask      = op_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data = {2{op_data[15:0]}};
      end
      default: begin
        mask      = '1;
        lane_data = op_data;
      end
    endcase
    store_val = (cur_word & ~mask) | (lane_data & mask);
  end

  // The array has no reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (reset && exec && op_wr && !acc_err)
      mem[idx] <= store_val;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lat_wr    <= 1'b0;
      lat_rd    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_f3    <= 3'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if ((state == IDLE) && req) begin
        lat_wr   <= bus.wr;
        lat_rd   <= bus.rd;
        lat_addr <= bus.addr;
        lat_data <= bus.wr_data;
        lat_f3   <= bus.funct3;
      end
      if (exec) begin
        state  <= RESP;
        busy_q <= 1'b1;
        done_q <= 1'b1;
        err_q  <= acc_err;
        if (op_rd && !acc_err)
          rd_data_q <= load_val;
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              state  <= WAIT;
              cnt    <= CNT_INIT;
              busy_q <= 1'b1;
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          RESP: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule
